// File: rtl/motor_pwm_decoder.sv
// motor_pwm_decoder: recovers the signed speed command behind a fwd/rev PWM
// pin pair. It counts fwd-only, rev-only and both-high cycles over
// back-to-back windows of 2^PERIOD_W clocks. At each window end it reports
// the saturated fwd-rev difference, plus brake and direction-fault flags.
module motor_pwm_decoder #(
  parameter int PERIOD_W    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fwd,
  input  logic              rev,
  output logic [PERIOD_W:0] speed,
  output logic              brake,
  output logic              dir_err,
  output logic              valid
);

  localparam int CNT_W = PERIOD_W + 1;
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [PERIOD_W-1:0] WIN_LAST = '1;
  localparam logic [CNT_W-1:0]    WIN_FULL = {1'b1, {PERIOD_W{1'b0}}};
  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEAS} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_f, sync_r;
  logic                   fs, rs;
  logic                   inc_f, inc_r, inc_b;

  logic [SET_W-1:0]    settle_cnt;
  logic [PERIOD_W-1:0] win_cnt;
  logic [CNT_W-1:0]    fwd_cnt, rev_cnt, brk_cnt;

  logic             settle_on, meas_on, win_end;

  logic             vld_p0;
  logic [CNT_W-1:0] fwd_p0, rev_p0, brk_p0;

  logic signed [PERIOD_W:0] speed_p1;
  logic                     brake_p1, dir_err_p1, vld_p1;

  // Speed is fwd-rev clamped to +/-(2^PERIOD_W-1). Because fwd+rev never
  // exceeds the window length, only a full window of one direction can
  // reach 2^PERIOD_W, and the other count is then zero. Clamping each count
  // before subtracting is therefore exact and keeps the math at PERIOD_W+1 bits.
  function automatic logic signed [PERIOD_W:0] sat_speed(
    input logic [CNT_W-1:0] f,
    input logic [CNT_W-1:0] r
  );
    logic [PERIOD_W-1:0] fc, rc;
    fc = f[PERIOD_W] ? '1 : f[PERIOD_W-1:0];
    rc = r[PERIOD_W] ? '1 : r[PERIOD_W-1:0];
    return $signed({1'b0, fc}) - $signed({1'b0, rc});
  endfunction

  function automatic logic is_brake(input logic [CNT_W-1:0] b);
    return (b == WIN_FULL);
  endfunction

  // Input synchronizers; reset to the idle brake level (both pins high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_f <= '1;
      sync_r <= '1;
    end else begin
      sync_f <= {sync_f[SYNC_STAGES-2:0], fwd};
      sync_r <= {sync_r[SYNC_STAGES-2:0], rev};
    end
  end

  assign fs    = sync_f[SYNC_STAGES-1];
  assign rs    = sync_r[SYNC_STAGES-1];
  assign inc_f = fs & ~rs;
  assign inc_r = rs & ~fs;
  assign inc_b = fs & rs;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: en low always aborts to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = SETTLE;
      SETTLE:  if (!en) state_nxt = IDLE;
               else if (settle_cnt == SET_LAST) state_nxt = MEAS;
      MEAS:    if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: counting qualifiers and end-of-window strobe
  always_comb begin
    settle_on = (state == SETTLE);
    meas_on   = (state == MEAS);
    win_end   = meas_on && (win_cnt == WIN_LAST);
  end

  // Settle timer flushes stale synchronizer contents before counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                settle_cnt <= '0;
    else if (settle_on && en)  settle_cnt <= settle_cnt + 1'b1;
    else                       settle_cnt <= '0;
  end

  // Window counter and accumulators; restart at window end, clear on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      fwd_cnt <= '0;
      rev_cnt <= '0;
      brk_cnt <= '0;
    end else if (meas_on && en && !win_end) begin
      win_cnt <= win_cnt + 1'b1;
      fwd_cnt <= fwd_cnt + CNT_W'(inc_f);
      rev_cnt <= rev_cnt + CNT_W'(inc_r);
      brk_cnt <= brk_cnt + CNT_W'(inc_b);
    end else begin
      win_cnt <= '0;
      fwd_cnt <= '0;
      rev_cnt <= '0;
      brk_cnt <= '0;
    end
  end

  // ---- stage p0: snapshot of final window counts (last sample folded in) ----
  // The snapshot is taken even if en drops on the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= win_end;
  end

  // Snapshot data registers, qualified by vld_p0
  always_ff @(posedge clk) begin
    if (win_end) begin
      fwd_p0 <= fwd_cnt + CNT_W'(inc_f);
      rev_p0 <= rev_cnt + CNT_W'(inc_r);
      brk_p0 <= brk_cnt + CNT_W'(inc_b);
    end
  end

  // ---- stage p1: registered results, held until the next completed window ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_p1   <= '0;
      brake_p1   <= 1'b0;
      dir_err_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        brake_p1   <= is_brake(brk_p0);
        speed_p1   <= is_brake(brk_p0) ? '0 : sat_speed(fwd_p0, rev_p0);
        dir_err_p1 <= (fwd_p0 != '0) && (rev_p0 != '0);
      end
    end
  end

  assign speed   = speed_p1;
  assign brake   = brake_p1;
  assign dir_err = dir_err_p1;
  assign valid   = vld_p1;

endmodule

// File: doc/motor_pwm_decoder.md
Name: motor_pwm_decoder

Overview:
- Measures a motor's fwd/rev PWM pin pair over fixed windows and recovers the signed speed command that produced it.
- Inverse of the motor-drive path: takes the fwd/rev pins a PWM motor driver produces and returns an 11-bit signed speed plus brake and direction-fault flags.
- Used for closed-loop self-check of the drive path and for bench/in-system monitoring of motor outputs.

Parameters:
PERIOD_W, 10, log2 of PWM period in clk cycles; measurement window = 2^PERIOD_W cycles.
SYNC_STAGES, 2, flop stages on the fwd/rev inputs (minimum 2).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  measurement enable
fwd  input  1  forward PWM pin under observation
rev  input  1  reverse PWM pin under observation
speed  output  PERIOD_W+1  signed two's-complement speed; last completed window
brake  output  1  last window had fwd=rev=1 on every cycle
dir_err  output  1  last window had both fwd-only and rev-only cycles
valid  output  1  one-cycle pulse when speed/brake/dir_err update

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - speed=0, brake=0, dir_err=0, valid=0.
  - Sync flops=1, the idle brake level.
  - Counters=0; FSM=IDLE.
- Input path: fwd/rev pass through SYNC_STAGES flops. All counting uses the synced values fs/rs.
- FSM states: IDLE, SETTLE, MEAS.
- IDLE:
  - Window counter and accumulators are held at 0.
  - Outputs hold their last values.
  - Go to SETTLE when en=1.
- SETTLE:
  - Waits SYNC_STAGES cycles to flush stale sync data; no counting.
  - Then go to MEAS with win_cnt=0.
- MEAS, per cycle:
  - Increment win_cnt (PERIOD_W bits, wraps).
  - fs&~rs: fwd_cnt++.
  - rs&~fs: rev_cnt++.
  - fs&rs: brk_cnt++.
  - Neither high (coast): no count.
  - Accumulators are PERIOD_W+1 bits wide and cannot overflow within one window.
- End of window, when win_cnt = 2^PERIOD_W-1:
  - That cycle's sample is included.
  - On the next edge, outputs are registered and valid=1 for exactly one cycle.
  - Accumulators restart from that cycle's sample, so windows are back-to-back with no gap cycle.
- Result rules:
  - brake = (brk_cnt == 2^PERIOD_W).
  - If brake=1: speed=0.
  - Otherwise speed = fwd_cnt - rev_cnt, saturated to ±(2^PERIOD_W-1), i.e. ±1023 at the default. A full-window fwd (raw 1024) therefore reports +1023.
  - Partial both-high cycles contribute nothing to speed and do not set brake.
  - dir_err = (fwd_cnt≠0 && rev_cnt≠0), evaluated regardless of brake.
- Alignment: the window need not be phase-aligned to the source PWM. For a steady PWM of period 2^PERIOD_W, any full window yields the exact duty.
- en=0 in any state:
  - Next state is IDLE and the partial window is discarded.
  - No valid pulse; outputs keep their last completed values.
  - If en falls on the final window cycle, the update still occurs on the next edge.
- Re-enable: first valid arrives SYNC_STAGES + 2^PERIOD_W + 1 cycles after en is sampled high.
- rst_n asserted mid-window: immediate return to reset values; no valid pulse.
- Latency from a pin change to its effect on counting: SYNC_STAGES cycles.

Test Plan:
- PWM drive path fed lft=+256, output pins fed to fwd/rev, en=1 -> from the first valid onward: speed=+256, brake=0, dir_err=0, valid spaced exactly 1024 cycles apart.
- lft=-300 (11'h6D4) -> speed=-300 (11'h6D4), brake=0, dir_err=0.
- lft=0 (drive holds fwd=rev=1) -> brake=1, speed=0; then fwd=1/rev=1 for only 1000 of 1024 cycles -> brake=0, speed=0.
- fwd=1, rev=0 held constantly -> speed=+1023 (saturated from raw 1024); rev=1, fwd=0 constantly -> speed=-1023.
- One window with 100 fwd-only cycles, 50 rev-only cycles, rest coast -> speed=+50, dir_err=1.
- en dropped at win_cnt=500, then re-raised 20 cycles later -> no valid for the aborted window; next valid exactly SYNC_STAGES+1025 cycles after re-enable; async rst_n pulse mid-window -> all outputs 0, no valid.
